// File: rtl/switch_press_repeat_if.sv
// Push-button conditioner signal bundle: raw switch in, debounced level and pulses out.
// The bench drives through the master modport and the conditioner sits on the slave modport.
interface switch_press_repeat_if;
  logic i_Switch;
  logic o_Switch;
  logic o_Press_Pulse;
  logic o_Release_Pulse;
  logic o_Repeating;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Press_Pulse,
    input  o_Release_Pulse,
    input  o_Repeating
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Press_Pulse,
    output o_Release_Pulse,
    output o_Repeating
  );
endinterface

// File: rtl/switch_press_repeat.sv
// Synchronises and debounces a push-button, then emits press, auto-repeat and release pulses
// so a digit counter can advance once per pulse without any edge detection of its own.
module switch_press_repeat #(
  parameter int c_DEBOUNCE_LIMIT = 250000,
  parameter int c_HOLD_LIMIT     = 12500000,
  parameter int c_REPEAT_LIMIT   = 2500000
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  switch_press_repeat_if.slave sw_if
);

  localparam int DB_W  = $clog2(c_DEBOUNCE_LIMIT);
  localparam int HLD_W = $clog2(c_HOLD_LIMIT);
  localparam int RPT_W = $clog2(c_REPEAT_LIMIT);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(c_DEBOUNCE_LIMIT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(c_HOLD_LIMIT - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(c_REPEAT_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [1:0]      sync_q, sync_d;
  logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic            deb_q, deb_d;

  state_t           state_q;
  logic [HLD_W-1:0] hold_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic             switch_q;
  logic             press_q;
  logic             release_q;
  logic             repeating_q;

  // deb_q is the debounced state; the FSM re-registers it as o_Switch so the level
  // and its press/release pulse always appear on the same edge.
  always_comb begin
    sync_d    = {sync_q[0], sw_if.i_Switch};
    deb_cnt_d = '0;
    deb_d     = deb_q;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  // A debounced fall is tested before any terminal count so release always wins.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      rpt_cnt_q   <= '0;
      switch_q    <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      switch_q  <= deb_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hold_cnt_q  <= '0;
          rpt_cnt_q   <= '0;
          repeating_q <= 1'b0;
          if (deb_q && !switch_q) begin
            state_q <= HELD;
            press_q <= 1'b1;
          end
        end
        HELD: begin
          if (!deb_q) begin
            state_q    <= IDLE;
            release_q  <= 1'b1;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HLD_LAST) begin
            state_q     <= REPEAT;
            press_q     <= 1'b1;
            repeating_q <= 1'b1;
            hold_cnt_q  <= '0;
            rpt_cnt_q   <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!deb_q) begin
            state_q     <= IDLE;
            release_q   <= 1'b1;
            repeating_q <= 1'b0;
            rpt_cnt_q   <= '0;
          end else if (rpt_cnt_q == RPT_LAST) begin
            press_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          hold_cnt_q  <= '0;
          rpt_cnt_q   <= '0;
          repeating_q <= 1'b0;
        end
      endcase
    end
  end

  assign sw_if.o_Switch        = switch_q;
  assign sw_if.o_Press_Pulse   = press_q;
  assign sw_if.o_Release_Pulse = release_q;
  assign sw_if.o_Repeating     = repeating_q;

endmodule

// File: tb/tb_switch_press_repeat.sv
// Directed-vector bench for switch_press_repeat with debounce 4, hold 10, repeat 3.
// Cycle c of a case is the c-th rising edge of that case; outputs are sampled 1 time unit after it.
module tb_switch_press_repeat;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_count = 0;
  int   err_count = 0;
  bit   mon_en = 1'b0;

  switch_press_repeat_if sw_if ();

  switch_press_repeat #(
    .c_DEBOUNCE_LIMIT(4),
    .c_HOLD_LIMIT    (10),
    .c_REPEAT_LIMIT  (3)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .sw_if(sw_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic applyStimulus(input logic sw, input logic rst_in);
    @(negedge clk);
    sw_if.i_Switch = sw;
    rst = rst_in;
    @(posedge clk);
    #1;
  endtask

  // stim bit c is the switch level for cycle c; pmask bit c marks an expected press pulse.
  task automatic run_case(input string name, input logic [63:0] stim, input int n_cycles,
                          input logic [63:0] pmask, input int sw_on, input int sw_off,
                          input int rep_on, input int rel_at);
    int seen;
    bit exp_rep;
    seen = 0;
    for (int c = 0; c < n_cycles; c++) begin
      applyStimulus(stim[c], 1'b0);
      exp_rep = (rep_on >= 0) && (c >= rep_on) && (c < sw_off);
      checkOutput($sformatf("%s c%0d switch", name, c), sw_if.o_Switch,
                  int'((c >= sw_on) && (c < sw_off)));
      checkOutput($sformatf("%s c%0d press", name, c), sw_if.o_Press_Pulse, int'(pmask[c]));
      checkOutput($sformatf("%s c%0d release", name, c), sw_if.o_Release_Pulse, int'(c == rel_at));
      checkOutput($sformatf("%s c%0d repeating", name, c), sw_if.o_Repeating, int'(exp_rep));
      if (sw_if.o_Press_Pulse) seen++;
    end
    checkOutput({name, " press count"}, seen, $countones(pmask));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("press_and_release", int'(sw_if.o_Press_Pulse & sw_if.o_Release_Pulse), 0);
      checkOutput("repeating_without_switch", int'(sw_if.o_Repeating & ~sw_if.o_Switch), 0);
    end
  end

  initial begin
    logic [63:0] rep_presses;
    rep_presses = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) |
                  (64'd1 << 25) | (64'd1 << 28) | (64'd1 << 31) | (64'd1 << 34);
    sw_if.i_Switch = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("reset switch", sw_if.o_Switch, 0);
    checkOutput("reset press", sw_if.o_Press_Pulse, 0);
    checkOutput("reset release", sw_if.o_Release_Pulse, 0);
    checkOutput("reset repeating", sw_if.o_Repeating, 0);
    idle_cycles(4);
    mon_en = 1'b1;

    // Held 8 cycles: the debounced level lasts 8 cycles, short of the hold limit.
    run_case("short", 64'hFF, 20, 64'd1 << 6, 6, 14, -1, 14);
    idle_cycles(6);

    // Held 30 cycles: repeats from 16 every 3; release at 36 sits between repeats.
    run_case("hold30", 64'h3FFF_FFFF, 40, rep_presses, 6, 36, 16, 36);
    idle_cycles(6);

    // Held 31 cycles: release lands on cycle 37, a repeat terminal count, so no press there.
    run_case("coincide", 64'h7FFF_FFFF, 42, rep_presses, 6, 37, 16, 37);
    idle_cycles(6);

    // Bounce 1,1,1,0,1,1 is rejected; a clean rise at 16 held 9 cycles presses at 22.
    run_case("bounce", 64'h01FF_0037, 36, 64'd1 << 22, 22, 31, -1, 31);
    idle_cycles(6);

    // Into REPEAT, then a one-cycle reset with the switch still held.
    run_case("pre_rst", 64'h001F_FFFF, 21, (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19),
             6, 99, 16, -1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid reset switch", sw_if.o_Switch, 0);
    checkOutput("mid reset press", sw_if.o_Press_Pulse, 0);
    checkOutput("mid reset release", sw_if.o_Release_Pulse, 0);
    checkOutput("mid reset repeating", sw_if.o_Repeating, 0);
    run_case("post_rst", 64'h001F_FFFF, 33,
             (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25),
             6, 27, 16, 27);
    idle_cycles(4);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
